gpu_blitter: RTL and testbench
==============================

// Module: gpu_blitter
// PURPOSE
//  Next-generation GPU draw engine between the command controller, main memory and framebuffer.
//  Executes one command at a time: DRAW (copy a sub-rectangle of an image), FILL (solid rectangle)
//  or CLEAR (whole framebuffer). DRAW supports signed clipped destinations, X/Y flip, optional
//  transparency and a pipelined, stallable memory port with up to MAX_OUT outstanding reads.
// PARAMETERS
//  FB_WIDTH   400  framebuffer width in pixels
//  FB_HEIGHT  240  framebuffer height in pixels
//  ADDR_W     32   memory address width (word = one pixel)
//  COLOR_W    16   pixel colour width
//  DIM_W      16   width of image width/height/offset fields
//  MAX_OUT    4    max outstanding memory reads (power of two, >=2)
//  TRANSP_BIT 0    colour bit that marks a pixel opaque; 0 there = transparent
//  XW/YW derived: $clog2(FB_WIDTH)+2 / $clog2(FB_HEIGHT)+2, signed destination coordinates
// PORTS
//  clk          in   1        clock
//  enable       in   1        synchronous active-low reset (0 = reset)
//  cmd_valid    in   1        command present
//  cmd_ready    out  1        engine accepts command (state IDLE)
//  cmd_op       in   2        0 DRAW, 1 FILL, 2 CLEAR, 3 reserved (accepted, no-op)
//  cmd_flip_x   in   1        DRAW: mirror horizontally
//  cmd_flip_y   in   1        DRAW: mirror vertically
//  cmd_transp   in   1        DRAW: honour TRANSP_BIT
//  cmd_addr     in   ADDR_W   image base address
//  cmd_src_x    in   DIM_W    source x offset in image
//  cmd_src_y    in   DIM_W    source y offset in image
//  cmd_img_w    in   DIM_W    image row pitch in pixels
//  cmd_w        in   DIM_W    rectangle width
//  cmd_h        in   DIM_W    rectangle height
//  cmd_dst_x    in   XW       signed destination left
//  cmd_dst_y    in   YW       signed destination top
//  cmd_color    in   COLOR_W  FILL/CLEAR colour
//  busy         out  1        command in progress (state != IDLE)
//  mem_read     out  1        read request valid
//  mem_ack      in   1        request accepted this cycle
//  mem_addr     out  ADDR_W   read address
//  mem_rvalid   in   1        read data valid (in request order)
//  mem_data     in   COLOR_W  read data
//  fb_write     out  1        write strobe (framebuffer always accepts)
//  fb_x         out  XW-1     write x, always < FB_WIDTH when fb_write
//  fb_y         out  YW-1     write y, always < FB_HEIGHT when fb_write
//  fb_color     out  COLOR_W  write colour
// BEHAVIOUR
//  Reset (enable=0, sync): state IDLE, cmd_ready=1 after release, busy=0, mem_read=0, fb_write=0,
//   fb_x/fb_y/fb_color=0, tag FIFO flushed. Reset mid-command aborts it; rvalid beats arriving
//   with an empty FIFO are discarded.
//  Handshake: command taken on cmd_valid&&cmd_ready (cycle T); all fields latched at T.
//  States: IDLE -> ISSUE (DRAW) | FILL (FILL/CLEAR) ; ISSUE -> DRAIN when last pixel issued;
//   DRAIN -> IDLE when FIFO empty and no pending write; FILL -> IDLE after last pixel.
//  cmd_w==0 or cmd_h==0 or op 3: state returns to IDLE at T+1, no mem_read, no fb_write.
//  Scan order row-major, col 0..w-1, row 0..h-1; one pixel per cycle max.
//  Clipping: dest (dst_x+col, dst_y+row) outside [0,FB_WIDTH)x[0,FB_HEIGHT) is skipped without
//   a memory request (costs one cycle). Arithmetic signed, XW/YW bits, no wrap.
//  Source pixel: sc = flip_x ? w-1-col : col; sr = flip_y ? h-1-row : row;
//   mem_addr = addr + src_x + sc + (src_y + sr)*img_w, truncated to ADDR_W.
//  ISSUE: mem_read high from T+1 for an in-bounds pixel; held with stable mem_addr until mem_ack.
//   On ack, dest coords pushed to tag FIFO. mem_read deasserted when FIFO holds MAX_OUT entries.
//  Response: on mem_rvalid, pop FIFO; next cycle fb_write = !cmd_transp || mem_data[TRANSP_BIT],
//   fb_x/fb_y = popped coords, fb_color = mem_data. Ack and rvalid in the same cycle both legal.
//  FILL: fb_write from T+1, colour = cmd_color, transparency ignored. CLEAR = FILL with
//   dst 0,0, w=FB_WIDTH, h=FB_HEIGHT, no flip.
//  cmd_ready rises the cycle after the last fb_write (or after DRAIN empties with no write).
// STRUCTURE
//  gpu_pkg: op encodings, state encodings, XW/YW helper functions.
//  Sub-module gpu_tag_fifo: sync FIFO, MAX_OUT deep, (XW-1)+(YW-1) bits, push/pop/full/empty,
//   flush on enable=0; simultaneous push+pop when full or empty is legal.
//  Top: scan counters, address datapath, FSM, output register stage.
// TESTING
//  1 DRAW 4x2 at (10,20), img_w=8, addr=0x100, mem_ack always 1, latency 3, no transp ->
//    8 writes at (10..13,20..21) with colours from 0x100..0x103, 0x108..0x10B.
//  2 Same with flip_x=1, flip_y=1 -> (10,20) gets word 0x10B; (13,21) gets word 0x100.
//  3 DRAW 4x4 at (-2,238) -> only 4 writes, x 0..1, y 238..239; exactly 4 mem_read acks.
//  4 mem_ack low 5 cycles, latency 10 -> never >4 outstanding, mem_addr stable while stalled.
//  5 cmd_transp=1, data alternating bit0=1/0 -> only opaque pixels written; FILL 3x1 colour
//    0x1234 ignores bit0 -> 3 writes.
//  6 CLEAR 0xFFFF -> 96000 writes then cmd_ready; enable=0 mid-DRAW -> fb_write low next cycle,
//    late rvalid discarded; cmd_w=0 -> idle at T+1, no traffic.

Source files
------------

// File: rtl/gpu_pkg.sv
// gpu_pkg: shared definitions for the GPU blitter.
//   op_e    : command opcodes carried on cmd_op
//   state_e : blitter control states
//   coord_w : width of a signed destination coordinate that can cover
//             one framebuffer extent with headroom for clipping
package gpu_pkg;

  typedef enum logic [1:0] {
    OP_DRAW  = 2'd0,
    OP_FILL  = 2'd1,
    OP_CLEAR = 2'd2,
    OP_NOP   = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_FILL,
    ST_DRAIN
  } state_e;

  function automatic int unsigned coord_w(input int unsigned extent);
    return $clog2(extent) + 2;
  endfunction

endpackage

// File: rtl/gpu_tag_fifo.sv
// gpu_tag_fifo: synchronous FIFO holding destination coordinates of
// memory reads that are in flight.
//   clk, enable (sync active-low reset / flush)
//   push, push_data : write side (ignored when full unless popping)
//   pop,  pop_data  : read side (ignored when empty), pop_data = head
//   full, empty     : occupancy flags
module gpu_tag_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             enable,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count == '0);
  assign full     = (count == (PW+1)'(DEPTH));
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (!enable) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      if (do_push && !do_pop)      count <= count + (PW+1)'(1);
      else if (!do_push && do_pop) count <= count - (PW+1)'(1);
    end
  end

endmodule

// File: rtl/gpu_blitter.sv
// gpu_blitter: rectangle draw engine (DRAW copy from memory, FILL, CLEAR).
//   clk, enable        : clock, sync active-low reset
//   cmd_*              : command handshake and fields, latched on accept
//   busy               : command in progress
//   mem_read/ack/addr  : stallable read request port
//   mem_rvalid/data    : in-order read responses
//   fb_write/x/y/color : framebuffer write port (always accepted)
module gpu_blitter
  import gpu_pkg::*;
#(
  parameter int unsigned FB_WIDTH   = 400,
  parameter int unsigned FB_HEIGHT  = 240,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned COLOR_W    = 16,
  parameter int unsigned DIM_W      = 16,
  parameter int unsigned MAX_OUT    = 4,
  parameter int unsigned TRANSP_BIT = 0,
  parameter int unsigned XW         = coord_w(FB_WIDTH),
  parameter int unsigned YW         = coord_w(FB_HEIGHT)
) (
  input  logic               clk,
  input  logic               enable,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic               cmd_flip_x,
  input  logic               cmd_flip_y,
  input  logic               cmd_transp,
  input  logic [ADDR_W-1:0]  cmd_addr,
  input  logic [DIM_W-1:0]   cmd_src_x,
  input  logic [DIM_W-1:0]   cmd_src_y,
  input  logic [DIM_W-1:0]   cmd_img_w,
  input  logic [DIM_W-1:0]   cmd_w,
  input  logic [DIM_W-1:0]   cmd_h,
  input  logic [XW-1:0]      cmd_dst_x,
  input  logic [YW-1:0]      cmd_dst_y,
  input  logic [COLOR_W-1:0] cmd_color,
  output logic               busy,
  output logic               mem_read,
  input  logic               mem_ack,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic               mem_rvalid,
  input  logic [COLOR_W-1:0] mem_data,
  output logic               fb_write,
  output logic [XW-2:0]      fb_x,
  output logic [YW-2:0]      fb_y,
  output logic [COLOR_W-1:0] fb_color
);

  localparam int unsigned TW    = (XW - 1) + (YW - 1);
  localparam int          FBW_S = int'(FB_WIDTH);
  localparam int          FBH_S = int'(FB_HEIGHT);

  state_e state, state_nx;

  logic                      flip_x_q, flip_y_q, transp_q;
  logic [ADDR_W-1:0]         addr_q;
  logic [DIM_W-1:0]          src_x_q, src_y_q, img_w_q, w_q, h_q;
  logic signed [XW-1:0]      dst_x_q;
  logic signed [YW-1:0]      dst_y_q;
  logic [COLOR_W-1:0]        color_q;
  logic [DIM_W-1:0]          col, row;

  logic                      wr_q;
  logic [XW-2:0]             wx_q;
  logic [YW-2:0]             wy_q;
  logic [COLOR_W-1:0]        wc_q;

  op_e                       op_in;
  logic                      accept, empty_rect, start_draw, start_fill;
  logic signed [31:0]        px, py;
  logic [XW-2:0]             px_lo;
  logic [YW-2:0]             py_lo;
  logic                      in_bounds, last_col, last_row, advance;
  logic [DIM_W-1:0]          sc, sr;
  logic                      tag_full, tag_empty, resp_valid;
  logic [TW-1:0]             tag_out;
  logic                      filling;

  assign op_in      = op_e'(cmd_op);
  assign cmd_ready  = (state == ST_IDLE);
  assign busy       = !cmd_ready;
  assign accept     = cmd_valid && cmd_ready;
  assign empty_rect = (op_in != OP_CLEAR) && ((cmd_w == '0) || (cmd_h == '0));
  assign start_draw = accept && (op_in == OP_DRAW) && !empty_rect;
  assign start_fill = accept && ((op_in == OP_CLEAR) || ((op_in == OP_FILL) && !empty_rect));

  // Destination of the current scan position, evaluated wide so that
  // clipping never sees a wrapped coordinate.
  assign px        = 32'(dst_x_q) + $signed(32'(col));
  assign py        = 32'(dst_y_q) + $signed(32'(row));
  assign px_lo     = (XW-1)'(dst_x_q) + (XW-1)'(col);
  assign py_lo     = (YW-1)'(dst_y_q) + (YW-1)'(row);
  assign in_bounds = (px >= 0) && (px < FBW_S) && (py >= 0) && (py < FBH_S);
  assign last_col  = (col == w_q - DIM_W'(1));
  assign last_row  = (row == h_q - DIM_W'(1));

  assign sc       = flip_x_q ? (w_q - DIM_W'(1) - col) : col;
  assign sr       = flip_y_q ? (h_q - DIM_W'(1) - row) : row;
  assign mem_addr = addr_q + ADDR_W'(src_x_q) + ADDR_W'(sc)
                  + (ADDR_W'(src_y_q) + ADDR_W'(sr)) * ADDR_W'(img_w_q);

  assign resp_valid = mem_rvalid && !tag_empty;

  gpu_tag_fifo #(
    .DEPTH (MAX_OUT),
    .WIDTH (TW)
  ) u_tag_fifo (
    .clk       (clk),
    .enable    (enable),
    .push      (mem_read && mem_ack),
    .push_data ({px_lo, py_lo}),
    .pop       (mem_rvalid),
    .pop_data  (tag_out),
    .full      (tag_full),
    .empty     (tag_empty)
  );

  always_comb begin
    state_nx = state;
    advance  = 1'b0;
    mem_read = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start_draw)      state_nx = ST_ISSUE;
        else if (start_fill) state_nx = ST_FILL;
      end
      ST_ISSUE: begin
        if (!in_bounds) begin
          advance = 1'b1;
        end else begin
          mem_read = !tag_full;
          advance  = !tag_full && mem_ack;
        end
        if (advance && last_col && last_row) state_nx = ST_DRAIN;
      end
      ST_FILL: begin
        advance = 1'b1;
        if (last_col && last_row) state_nx = ST_IDLE;
      end
      ST_DRAIN: begin
        if (tag_empty) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!enable) begin
      state <= ST_IDLE;
      col   <= '0;
      row   <= '0;
      wr_q  <= 1'b0;
      wx_q  <= '0;
      wy_q  <= '0;
      wc_q  <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        flip_x_q <= (op_in != OP_CLEAR) && cmd_flip_x;
        flip_y_q <= (op_in != OP_CLEAR) && cmd_flip_y;
        transp_q <= cmd_transp;
        addr_q   <= cmd_addr;
        src_x_q  <= cmd_src_x;
        src_y_q  <= cmd_src_y;
        img_w_q  <= cmd_img_w;
        color_q  <= cmd_color;
        if (op_in == OP_CLEAR) begin
          w_q     <= DIM_W'(FB_WIDTH);
          h_q     <= DIM_W'(FB_HEIGHT);
          dst_x_q <= '0;
          dst_y_q <= '0;
        end else begin
          w_q     <= cmd_w;
          h_q     <= cmd_h;
          dst_x_q <= cmd_dst_x;
          dst_y_q <= cmd_dst_y;
        end
        col <= '0;
        row <= '0;
      end else if (advance) begin
        if (last_col) begin
          col <= '0;
          row <= row + DIM_W'(1);
        end else begin
          col <= col + DIM_W'(1);
        end
      end
      wr_q <= resp_valid && (!transp_q || mem_data[TRANSP_BIT]);
      if (resp_valid) begin
        {wx_q, wy_q} <= tag_out;
        wc_q         <= mem_data;
      end
    end
  end

  // FILL pixels need no memory round trip, so they bypass the response
  // register to start writing the cycle after accept; no read response can
  // be pending while in FILL because DRAIN only exits with the FIFO empty.
  assign filling  = (state == ST_FILL);
  assign fb_write = filling ? in_bounds : wr_q;
  assign fb_x     = filling ? px_lo     : wx_q;
  assign fb_y     = filling ? py_lo     : wy_q;
  assign fb_color = filling ? color_q   : wc_q;

endmodule

// File: tb/tb_gpu_blitter.sv
`timescale 1ns/1ps
module tb_gpu_blitter;

  localparam int FB_W = 40;
  localparam int FB_H = 240;
  localparam int MAXO = 4;
  localparam int XW   = $clog2(FB_W) + 2;
  localparam int YW   = $clog2(FB_H) + 2;

  logic          clk = 1'b0;
  logic          enable = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_op = '0;
  logic          cmd_flip_x = 1'b0, cmd_flip_y = 1'b0, cmd_transp = 1'b0;
  logic [31:0]   cmd_addr = '0;
  logic [15:0]   cmd_src_x = '0, cmd_src_y = '0, cmd_img_w = '0, cmd_w = '0, cmd_h = '0;
  logic [XW-1:0] cmd_dst_x = '0;
  logic [YW-1:0] cmd_dst_y = '0;
  logic [15:0]   cmd_color = '0;
  logic          busy;
  logic          mem_read;
  logic          mem_ack = 1'b0;
  logic [31:0]   mem_addr;
  logic          mem_rvalid = 1'b0;
  logic [15:0]   mem_data = '0;
  logic          fb_write;
  logic [XW-2:0] fb_x;
  logic [YW-2:0] fb_y;
  logic [15:0]   fb_color;

  always #5 clk = ~clk;

  gpu_blitter #(
    .FB_WIDTH  (FB_W),
    .FB_HEIGHT (FB_H),
    .MAX_OUT   (MAXO)
  ) dut (
    .clk(clk), .enable(enable), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_flip_x(cmd_flip_x), .cmd_flip_y(cmd_flip_y),
    .cmd_transp(cmd_transp), .cmd_addr(cmd_addr), .cmd_src_x(cmd_src_x),
    .cmd_src_y(cmd_src_y), .cmd_img_w(cmd_img_w), .cmd_w(cmd_w), .cmd_h(cmd_h),
    .cmd_dst_x(cmd_dst_x), .cmd_dst_y(cmd_dst_y), .cmd_color(cmd_color),
    .busy(busy), .mem_read(mem_read), .mem_ack(mem_ack), .mem_addr(mem_addr),
    .mem_rvalid(mem_rvalid), .mem_data(mem_data), .fb_write(fb_write),
    .fb_x(fb_x), .fb_y(fb_y), .fb_color(fb_color)
  );

  typedef struct { int x; int y; int c; } wr_t;
  typedef struct { int a; int due; } pend_t;
  typedef struct {
    int op; int fx; int fy; int tr; int addr; int sx; int sy; int iw;
    int w; int h; int dx; int dy; int color; int lat; int ackm;
    int exp_wr; int exp_ack; int ends; int first_c; int last_c;
  } vec_t;

  int    n_cmp = 0;
  int    n_bad = 0;
  wr_t   obs_q[$];
  wr_t   exp_q[$];
  pend_t pend_q[$];
  int    cyc = 0, lat = 3, ackm = 0, mask = 0;
  int    ack_cnt = 0, rd_cycles = 0, outstanding = 0;
  logic  prev_stall = 1'b0;
  logic [31:0] prev_addr = '0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic longint pk(input wr_t w);
    return (longint'(w.x) << 32) | (longint'(w.y) << 16) | longint'(w.c);
  endfunction

  // Memory: word at address a holds (a ^ mask) truncated to 16 bits.
  always @(negedge clk) begin
    cyc++;
    if (fb_write === 1'b1) obs_q.push_back('{int'(fb_x), int'(fb_y), int'(fb_color)});
    if (mem_read === 1'b1) rd_cycles++;
    if (prev_stall === 1'b1) begin
      chk("stall_read_held", longint'(mem_read), 1);
      chk("stall_addr_stable", longint'(mem_addr), longint'(prev_addr));
    end
    case (ackm)
      0:       mem_ack = 1'b1;
      1:       mem_ack = ((cyc % 6) == 5);
      default: mem_ack = ($urandom_range(0, 3) != 0);
    endcase
    prev_stall = (mem_read === 1'b1) && !mem_ack;
    prev_addr  = mem_addr;
    if ((mem_read === 1'b1) && mem_ack) begin
      chk("outstanding_limit", longint'(outstanding < MAXO), 1);
      outstanding++;
      ack_cnt++;
      pend_q.push_back('{int'(mem_addr), cyc + lat});
    end
    mem_rvalid = 1'b0;
    if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
      mem_rvalid = 1'b1;
      mem_data   = 16'(pend_q[0].a ^ mask);
      pend_q.pop_front();
      if (outstanding > 0) outstanding--;
    end
  end

  task automatic model(input vec_t v, output int nacks);
    int w, h, dx, dy, fx, fy, px, py, sc, sr, a, d;
    exp_q.delete();
    nacks = 0;
    w = v.w; h = v.h; dx = v.dx; dy = v.dy; fx = v.fx; fy = v.fy;
    if (v.op == 2) begin w = FB_W; h = FB_H; dx = 0; dy = 0; fx = 0; fy = 0; end
    if (v.op == 3) return;
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        px = dx + c;
        py = dy + r;
        if (px < 0 || px >= FB_W || py < 0 || py >= FB_H) continue;
        if (v.op == 0) begin
          sc = (fx != 0) ? w - 1 - c : c;
          sr = (fy != 0) ? h - 1 - r : r;
          a  = v.addr + v.sx + sc + (v.sy + sr) * v.iw;
          d  = (a ^ mask) & 'hFFFF;
          nacks++;
          if (v.tr == 0 || d[0]) exp_q.push_back('{px, py, d});
        end else begin
          exp_q.push_back('{px, py, v.color & 'hFFFF});
        end
      end
    end
  endtask

  task automatic drive(input vec_t v);
    cmd_op     = 2'(v.op);
    cmd_flip_x = (v.fx != 0);
    cmd_flip_y = (v.fy != 0);
    cmd_transp = (v.tr != 0);
    cmd_addr   = 32'(v.addr);
    cmd_src_x  = 16'(v.sx);
    cmd_src_y  = 16'(v.sy);
    cmd_img_w  = 16'(v.iw);
    cmd_w      = 16'(v.w);
    cmd_h      = 16'(v.h);
    cmd_dst_x  = XW'(v.dx);
    cmd_dst_y  = YW'(v.dy);
    cmd_color  = 16'(v.color);
    cmd_valid  = 1'b1;
  endtask

  task automatic run_cmd(input vec_t v, input string nm);
    int nacks, budget;
    model(v, nacks);
    lat  = v.lat;
    ackm = v.ackm;
    @(negedge clk);
    budget = 0;
    while (cmd_ready !== 1'b1 && budget < 200) begin @(negedge clk); budget++; end
    obs_q.delete();
    ack_cnt = 0;
    drive(v);
    @(negedge clk);
    cmd_valid = 1'b0;
    budget = 0;
    while (cmd_ready !== 1'b1 && budget < 30000) begin @(negedge clk); budget++; end
    chk({nm, "_done"}, longint'(cmd_ready), 1);
    chk({nm, "_nwrites"}, obs_q.size(), exp_q.size());
    chk({nm, "_nacks"}, ack_cnt, nacks);
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
      chk({nm, "_pix"}, pk(obs_q[i]), pk(exp_q[i]));
  endtask

  vec_t tab[10];
  vec_t rv;
  int   rc0, budget;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    //          op fx fy tr addr    sx sy iw  w   h  dx  dy  color   lat ackm wr    ack ends first   last
    tab[0] = '{0, 0, 0, 0, 'h100,  0, 0, 8,  4,  2, 10, 20,  0,      3,  0,   8,    8,  1, 'h100, 'h10B};
    tab[1] = '{0, 1, 1, 0, 'h100,  0, 0, 8,  4,  2, 10, 20,  0,      3,  0,   8,    8,  1, 'h10B, 'h100};
    tab[2] = '{0, 0, 0, 0, 'h400,  0, 0, 16, 4,  4, -2, 238, 0,      3,  0,   4,    4,  0, 0,     0};
    tab[3] = '{0, 0, 0, 0, 'h800,  0, 0, 8,  8,  3,  0,  0,  0,      10, 1,   24,   24, 0, 0,     0};
    tab[4] = '{0, 0, 0, 1, 'h200,  0, 0, 8,  4,  2,  3,  3,  0,      2,  0,   4,    8,  0, 0,     0};
    tab[5] = '{1, 0, 0, 1, 0,      0, 0, 0,  3,  1,  1,  1, 'h1234,  3,  0,   3,    0,  1, 'h1234,'h1234};
    tab[6] = '{3, 0, 0, 0, 'h100,  0, 0, 8,  4,  2,  0,  0,  0,      3,  0,   0,    0,  0, 0,     0};
    tab[7] = '{1, 0, 0, 0, 0,      0, 0, 0,  5,  0,  0,  0, 'h55,    3,  0,   0,    0,  0, 0,     0};
    tab[8] = '{2, 0, 0, 0, 0,      0, 0, 0,  0,  0,  5,  5, 'hFFFF,  3,  0,   9600, 0,  1, 'hFFFF,'hFFFF};
    tab[9] = '{0, 1, 0, 0, 'h1000, 3, 2, 20, 5,  2, 38,  0,  0,      4,  2,   4,    4,  0, 0,     0};

    repeat (3) @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
    chk("reset_cmd_ready", longint'(cmd_ready), 1);
    chk("reset_busy", longint'(busy), 0);
    chk("reset_mem_read", longint'(mem_read), 0);
    chk("reset_fb_write", longint'(fb_write), 0);
    chk("reset_fb_xy", longint'({fb_x, fb_y}), 0);
    chk("reset_fb_color", longint'(fb_color), 0);

    mask = 0;
    for (int i = 0; i < 10; i++) begin
      run_cmd(tab[i], $sformatf("vec%0d", i));
      chk($sformatf("vec%0d_const_writes", i), obs_q.size(), tab[i].exp_wr);
      chk($sformatf("vec%0d_const_acks", i), ack_cnt, tab[i].exp_ack);
      if (tab[i].ends != 0 && obs_q.size() > 0) begin
        chk($sformatf("vec%0d_first_color", i), obs_q[0].c, tab[i].first_c);
        chk($sformatf("vec%0d_last_color", i), obs_q[obs_q.size()-1].c, tab[i].last_c);
      end
    end

    // Zero-width DRAW: back in IDLE the cycle after accept, no traffic.
    rv = tab[0];
    rv.w = 0;
    @(negedge clk);
    obs_q.delete();
    rc0 = rd_cycles;
    drive(rv);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("zero_w_ready_t1", longint'(cmd_ready), 1);
    chk("zero_w_busy_t1", longint'(busy), 0);
    repeat (5) @(negedge clk);
    chk("zero_w_no_reads", rd_cycles - rc0, 0);
    chk("zero_w_no_writes", obs_q.size(), 0);

    // FILL writes its first pixel in the cycle after accept.
    rv = tab[5];
    rv.dx = 7; rv.dy = 9;
    drive(rv);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("fill_t1_write", longint'(fb_write), 1);
    chk("fill_t1_xy", longint'({fb_x, fb_y}), longint'({7'(7), 9'(9)}));
    repeat (4) @(negedge clk);

    // Reset during a DRAW: outputs drop, late read beats are discarded.
    rv = tab[0];
    rv.addr = 'h300;
    lat = 10; ackm = 0; mask = 0;
    drive(rv);
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    chk("abort_fb_write", longint'(fb_write), 0);
    chk("abort_mem_read", longint'(mem_read), 0);
    chk("abort_ready", longint'(cmd_ready), 1);
    enable = 1'b1;
    obs_q.delete();
    chk("abort_beats_pending", longint'(pend_q.size() > 0), 1);
    budget = 0;
    while (pend_q.size() > 0 && budget < 50) begin @(negedge clk); budget++; end
    chk("abort_beats_delivered", pend_q.size(), 0);
    repeat (3) @(negedge clk);
    chk("abort_late_beats_ignored", obs_q.size(), 0);

    for (int n = 0; n < 25; n++) begin
      rv.op    = ($urandom_range(0, 3) == 0) ? 1 : 0;
      rv.fx    = $urandom_range(0, 1);
      rv.fy    = $urandom_range(0, 1);
      rv.tr    = $urandom_range(0, 1);
      rv.addr  = $urandom_range(0, 'hFFFFF);
      rv.sx    = $urandom_range(0, 50);
      rv.sy    = $urandom_range(0, 50);
      rv.iw    = $urandom_range(1, 64);
      rv.w     = $urandom_range(1, 6);
      rv.h     = $urandom_range(1, 5);
      rv.dx    = $urandom_range(0, FB_W + 10) - 8;
      rv.dy    = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 12) - 6
                                             : FB_H - $urandom_range(0, 6);
      rv.color = $urandom_range(0, 'hFFFF);
      rv.lat   = $urandom_range(1, 12);
      rv.ackm  = $urandom_range(0, 2);
      mask     = $urandom_range(0, 'hFFFF);
      run_cmd(rv, $sformatf("rand%0d", n));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
